// File: rtl/link_ddr_rx_assembler_if.sv
// Link DDR receive bus: io-side byte beats, core-side valid/yumi word port, status flags.
// LINK_RX_WORD_CNT_EN adds the accepted-word counter to the bus.
interface link_ddr_rx_assembler_if #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 4
);
  logic [1:0]                   io_valid_i;
  logic [2*BYTE_W-1:0]          io_data_i;
  logic [WORD_BYTES*BYTE_W-1:0] core_data_o;
  logic                         core_valid_o;
  logic                         core_yumi_i;
  logic                         token_o;
  logic                         overflow_o;
  logic                         proto_err_o;
`ifdef LINK_RX_WORD_CNT_EN
  logic [15:0]                  rx_word_cnt_o;

  modport master (output io_valid_i, io_data_i, core_yumi_i,
                  input  core_data_o, core_valid_o, token_o, overflow_o, proto_err_o, rx_word_cnt_o);
  modport slave  (input  io_valid_i, io_data_i, core_yumi_i,
                  output core_data_o, core_valid_o, token_o, overflow_o, proto_err_o, rx_word_cnt_o);
`else
  modport master (output io_valid_i, io_data_i, core_yumi_i,
                  input  core_data_o, core_valid_o, token_o, overflow_o, proto_err_o);
  modport slave  (input  io_valid_i, io_data_i, core_yumi_i,
                  output core_data_o, core_valid_o, token_o, overflow_o, proto_err_o);
`endif
endinterface

// File: rtl/link_ddr_rx_assembler.sv
// Reassembles registered DDR byte pairs into little-endian core words, buffers them in a
// small FIFO behind valid/yumi, and returns decimated credit on token_o. Optional: LINK_RX_WORD_CNT_EN.
module link_ddr_rx_assembler #(
  parameter int BYTE_W              = 8,
  parameter int WORD_BYTES          = 4,
  parameter int FIFO_DEPTH          = 4,
  parameter int LG_TOKEN_DECIMATION = 3
) (
  input logic                   clk,
  input logic                   rst,
  link_ddr_rx_assembler_if.slave bus
);
  localparam int WORD_W = WORD_BYTES * BYTE_W;
  localparam int CNT_W  = $clog2(WORD_BYTES);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0]  cnt_q, asm_cnt;
  logic [WORD_W-1:0] part_q, asm_word, cmpl_word;
  logic              cmpl;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_n;
  logic [OCC_W-1:0]  occ, occ_n, remain;
  logic              pop, full, push_ok;
  logic [WORD_W-1:0] head_q, head_n;
  logic              valid_q, token_q, ovf_q, perr_q;
  logic [LG_TOKEN_DECIMATION-1:0] dec_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Step through the first byte then the second; a word completing on the first byte
  // lets the second byte start the next word in the same cycle.
  always_comb begin
    asm_word  = part_q;
    asm_cnt   = cnt_q;
    cmpl      = 1'b0;
    cmpl_word = part_q;
    if (bus.io_valid_i[0]) begin
      asm_word[asm_cnt*BYTE_W +: BYTE_W] = bus.io_data_i[BYTE_W-1:0];
      if (asm_cnt == LAST) begin
        cmpl      = 1'b1;
        cmpl_word = asm_word;
        asm_cnt   = '0;
      end else begin
        asm_cnt = asm_cnt + 1'b1;
      end
      if (bus.io_valid_i[1]) begin
        asm_word[asm_cnt*BYTE_W +: BYTE_W] = bus.io_data_i[2*BYTE_W-1:BYTE_W];
        if (asm_cnt == LAST) begin
          cmpl      = 1'b1;
          cmpl_word = asm_word;
          asm_cnt   = '0;
        end else begin
          asm_cnt = asm_cnt + 1'b1;
        end
      end
    end
  end

  assign pop     = valid_q & bus.core_yumi_i;
  assign full    = (occ == OCC_W'(FIFO_DEPTH));
  assign push_ok = cmpl & (~full | pop);
  assign occ_n   = occ + OCC_W'(push_ok) - OCC_W'(pop);
  assign remain  = occ - OCC_W'(pop);
  assign rd_n    = pop ? ptr_inc(rd_ptr) : rd_ptr;
  // With nothing left behind the pop, the new head can only be the word pushed now.
  assign head_n  = (remain == '0) ? cmpl_word : mem[rd_n];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cmpl_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      part_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      dec_q   <= '0;
      token_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      cnt_q   <= asm_cnt;
      part_q  <= asm_word;
      rd_ptr  <= rd_n;
      occ     <= occ_n;
      valid_q <= (occ_n != '0);
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (occ_n != '0) head_q <= head_n;
      if (cmpl && !push_ok) ovf_q <= 1'b1;
      if (bus.io_valid_i == 2'b10) perr_q <= 1'b1;
      if (pop) begin
        dec_q <= dec_q + 1'b1;
        if (&dec_q) token_q <= ~token_q;
      end
    end
  end

`ifdef LINK_RX_WORD_CNT_EN
  logic [15:0] wcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wcnt_q <= '0;
    else if (push_ok) wcnt_q <= wcnt_q + 16'd1;
  end
  assign bus.rx_word_cnt_o = wcnt_q;
`endif

  assign bus.core_data_o  = head_q;
  assign bus.core_valid_o = valid_q;
  assign bus.token_o      = token_q;
  assign bus.overflow_o   = ovf_q;
  assign bus.proto_err_o  = perr_q;
endmodule
